serial_uart_bridge: RTL
=======================

Name: serial_uart_bridge

Overview:
- Device-side end of the processor's serial MMIO port.
- Consumes the bytes the core writes (serial_out / serial_wren_out) and shifts them out as 8N1 UART frames on a TX pin.
- Deserialises frames from an RX pin, then presents each byte with valid/ready status back to the core (serial_in / serial_valid_in / serial_ready_in).
- Sits at top level between the processor's serial pins and the board UART pins.

Parameters:
- CLK_HZ, 50000000, clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD, rounded down; DIV >= 4 is required.
- TX_DEPTH, 8, TX FIFO entries; must be a power of two and >= 2.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- tx_data_in  in  8  byte to send; connects to the core's serial_out.
- tx_wren_in  in  1  one-cycle write strobe; connects to serial_wren_out.
- tx_ready_out  out  1  TX FIFO not full; connects to serial_ready_in.
- rx_rden_in  in  1  consume strobe; connects to serial_rden_out.
- rx_data_out  out  8  received byte; connects to serial_in.
- rx_valid_out  out  1  rx_data_out holds an unread byte; connects to serial_valid_in.
- rx_overrun_out  out  1  sticky flag: a received byte was lost.
- uart_txd_out  out  1  UART transmit line; idle level is high.
- uart_rxd_in  in  1  UART receive line; asynchronous to clock.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-frame):
  - uart_txd_out = 1, tx_ready_out = 1, rx_valid_out = 0, rx_overrun_out = 0, rx_data_out = 0.
  - TX FIFO emptied; both FSMs return to IDLE; baud counters = 0.
- TX FIFO:
  - A write is accepted on a rising edge with tx_wren_in = 1 and tx_ready_out = 1.
  - A write while full is silently dropped; FIFO and pointers are unchanged.
  - tx_ready_out = (count != TX_DEPTH), driven from a register.
  - A write and a pop in the same cycle leave count unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: txd = 0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each; 3-bit index.
  - STOP: txd = 1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go to START directly (no idle gap); otherwise go to IDLE.
  - Latency: a write to an empty FIFO while IDLE drives txd low on the 2nd rising edge after the write edge.
- RX path:
  - uart_rxd_in passes through a 2-flop synchroniser.
  - IDLE: on synchronised high-to-low, go to START with the counter loaded to DIV/2.
  - START: at mid-bit, if the line is high (glitch), return to IDLE; otherwise go to DATA.
  - DATA: sample each bit every DIV cycles, LSB first.
  - STOP: sample once. If high, deliver the byte. If low (framing error), discard the byte and wait in IDLE until the line is high before re-arming.
- RX holding register (single entry):
  - Delivery while rx_valid_out = 0: rx_data_out loads the byte and rx_valid_out = 1 on the next edge.
  - rx_rden_in with rx_valid_out = 1: rx_valid_out = 0 on the next edge and rx_overrun_out is cleared. rx_rden_in with rx_valid_out = 0 has no effect.
  - Delivery while valid and no rden: the new byte is dropped, rx_overrun_out = 1, and rx_data_out keeps the old byte.
  - Delivery and rden in the same cycle: the new byte is loaded, rx_valid_out stays 1, and no overrun is flagged.
- The TX and RX paths are fully independent; full-duplex operation is supported.

Optional Feature:
- Macro: SERIAL_BRIDGE_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit (XOR of the data bits) between DATA and STOP, lasting DIV cycles; frame is 8E1.
  - RX samples the parity bit; a mismatch discards the byte and sets the sticky output rx_parity_err_out. rx_parity_err_out clears on rx_rden_in or reset.
- Undefined: 8N1 frames only; the PARITY state and the rx_parity_err_out port do not exist.

Test Plan (CLK_HZ=1000000, BAUD=100000, so DIV=10):
- Write 0xA5 while idle -> txd low 2 edges later; bits 1,0,1,0,0,1,0,1 at 10 cycles each; stop high; frame is 100 cycles.
- Write 9 bytes in 9 consecutive cycles -> byte 1 popped immediately, 8 held; tx_ready_out low after the 9th write; a 10th write is dropped. Frames are back-to-back, exactly 9 frames.
- Drive an RX frame of 0x3C -> rx_valid_out = 1 one edge after the stop-bit sample with rx_data_out = 0x3C. Pulse rx_rden_in -> valid = 0.
- Send 0x11 then 0x22 without reading -> rx_data_out = 0x11 and rx_overrun_out = 1. rx_rden_in -> overrun cleared.
- Drive a 3-cycle low glitch on rxd -> no byte delivered. Drive a frame with the stop bit low -> no valid; the next good frame 0x55 is received.
- Assert reset mid-TX frame -> txd = 1 immediately, tx_ready_out = 1. After release, a write of 0x01 sends a clean frame.

Source files
------------

// File: rtl/serial_uart_bridge.sv
// serial_uart_bridge: device-side UART endpoint for the core's serial MMIO port.
// TX: TX_DEPTH-entry FIFO feeding a UART serialiser (8N1).
// RX: 2-flop synchroniser, mid-bit sampling deserialiser, single-entry holding
// register with a sticky overrun flag.
// Optional build macro SERIAL_BRIDGE_PARITY_EN: 8E1 frames on both directions and
// the rx_parity_err_out sticky flag.
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | line high, waiting for a FIFO entry
//   TX_START  | start bit (low) for DIV cycles
//   TX_DATA   | 8 data bits LSB first, DIV cycles each
//   TX_PARITY | even parity bit (parity build only)
//   TX_STOP   | stop bit (high); chains straight into the next frame if queued
// RX FSM
//   state     | meaning
//   RX_IDLE   | waiting for a synchronised high-to-low edge
//   RX_START  | confirm start bit at mid-bit, reject glitches
//   RX_DATA   | sample 8 bits at mid-bit, LSB first
//   RX_PARITY | check even parity (parity build only)
//   RX_STOP   | sample stop bit; deliver byte only if high
module serial_uart_bridge #(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  output logic       tx_ready_out,
  input  logic       rx_rden_in,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  output logic       rx_overrun_out,
`ifdef SERIAL_BRIDGE_PARITY_EN
  output logic       rx_parity_err_out,
`endif
  output logic       uart_txd_out,
  input  logic       uart_rxd_in
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(TX_DEPTH);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef SERIAL_BRIDGE_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef SERIAL_BRIDGE_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt, fifo_cnt_next;
  logic          fifo_push, fifo_pop;

  assign fifo_push = tx_wren_in && tx_ready_out;

  // FIFO storage; contents are don't-care while unoccupied, so no reset
  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem[wr_ptr] <= tx_data_in;
  end

  // occupancy after this cycle's push/pop
  always_comb begin
    fifo_cnt_next = fifo_cnt;
    if (fifo_push && !fifo_pop)      fifo_cnt_next = fifo_cnt + 1'b1;
    else if (!fifo_push && fifo_pop) fifo_cnt_next = fifo_cnt - 1'b1;
  end

  // pointers, count and registered not-full flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      tx_ready_out <= 1'b1;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt     <= fifo_cnt_next;
      tx_ready_out <= (fifo_cnt_next != FULL_CNT);
    end
  end

  // ---------------- TX serialiser ----------------
  tx_state_t     tx_state, tx_state_next;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    tx_shift;
  logic [2:0]    tx_bit;
  logic          tx_cnt_done, tx_shift_en, tx_line;
`ifdef SERIAL_BRIDGE_PARITY_EN
  logic          tx_par;
`endif

  assign tx_cnt_done = (tx_cnt == '0);

  // TX next state, FIFO pop and line level
  always_comb begin
    tx_state_next = tx_state;
    fifo_pop      = 1'b0;
    tx_shift_en   = 1'b0;
    tx_line       = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (fifo_cnt != '0) begin
          fifo_pop      = 1'b1;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_cnt_done) tx_state_next = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_cnt_done) begin
          tx_shift_en = 1'b1;
          if (tx_bit == 3'd7) begin
`ifdef SERIAL_BRIDGE_PARITY_EN
            tx_state_next = TX_PARITY;
`else
            tx_state_next = TX_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_BRIDGE_PARITY_EN
      TX_PARITY: begin
        tx_line = tx_par;
        if (tx_cnt_done) tx_state_next = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (tx_cnt_done) begin
          if (fifo_cnt != '0) begin
            fifo_pop      = 1'b1;
            tx_state_next = TX_START;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // TX state, baud down-counter, shift register; txd is registered so the
  // line is glitch-free (one cycle behind the state)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_shift     <= '0;
      tx_bit       <= '0;
      uart_txd_out <= 1'b1;
`ifdef SERIAL_BRIDGE_PARITY_EN
      tx_par       <= 1'b0;
`endif
    end else begin
      tx_state     <= tx_state_next;
      uart_txd_out <= tx_line;
      if (fifo_pop) begin
        tx_shift <= fifo_mem[rd_ptr];
        tx_cnt   <= CNT_BIT;
        tx_bit   <= '0;
`ifdef SERIAL_BRIDGE_PARITY_EN
        tx_par   <= ^fifo_mem[rd_ptr];
`endif
      end else if (tx_state != TX_IDLE) begin
        tx_cnt <= tx_cnt_done ? CNT_BIT : tx_cnt - 1'b1;
        if (tx_shift_en) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 1'b1;
        end
      end
    end
  end

  // ---------------- RX deserialiser ----------------
  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     rx_state, rx_state_next;
  logic [CW-1:0] rx_cnt;
  logic [7:0]    rx_shift;
  logic [2:0]    rx_bit;
  logic          rx_cnt_done, rx_sample, rx_good, rx_done;
`ifdef SERIAL_BRIDGE_PARITY_EN
  logic          rx_par_bad;
`endif

  assign rx_cnt_done = (rx_cnt == '0);

  // 2-flop synchroniser plus one delayed copy for edge detection; reset to
  // the idle level so release of reset never looks like a start edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX next state; edge-triggered arming means a framing error naturally
  // waits for the line to return high before the next start is accepted
  always_comb begin
    rx_state_next = rx_state;
    rx_sample     = 1'b0;
    rx_good       = 1'b0;
`ifdef SERIAL_BRIDGE_PARITY_EN
    rx_par_bad    = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) rx_state_next = RX_START;
      end
      RX_START: begin
        if (rx_cnt_done) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_cnt_done) begin
          rx_sample = 1'b1;
          if (rx_bit == 3'd7) begin
`ifdef SERIAL_BRIDGE_PARITY_EN
            rx_state_next = RX_PARITY;
`else
            rx_state_next = RX_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_BRIDGE_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_done) begin
          if (rx_sync != ^rx_shift) begin
            rx_par_bad    = 1'b1;
            rx_state_next = RX_IDLE;
          end else begin
            rx_state_next = RX_STOP;
          end
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt_done) begin
          rx_good       = rx_sync;
          rx_state_next = RX_IDLE;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // RX state, half-bit preload in IDLE, bit sampling, delivery pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_state <= rx_state_next;
      rx_done  <= rx_good;
      if (rx_state == RX_IDLE) begin
        rx_cnt <= CNT_HALF;
        rx_bit <= '0;
      end else begin
        rx_cnt <= rx_cnt_done ? CNT_BIT : rx_cnt - 1'b1;
        if (rx_sample) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 1'b1;
        end
      end
    end
  end

  // single-entry holding register with sticky overrun
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_data_out    <= '0;
      rx_valid_out   <= 1'b0;
      rx_overrun_out <= 1'b0;
    end else begin
      if (rx_done && (!rx_valid_out || rx_rden_in)) begin
        rx_data_out  <= rx_shift;
        rx_valid_out <= 1'b1;
      end else if (rx_rden_in) begin
        rx_valid_out <= 1'b0;
      end
      if (rx_done && rx_valid_out && !rx_rden_in) rx_overrun_out <= 1'b1;
      else if (rx_rden_in && rx_valid_out)        rx_overrun_out <= 1'b0;
    end
  end

`ifdef SERIAL_BRIDGE_PARITY_EN
  // sticky parity error, cleared by a read strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          rx_parity_err_out <= 1'b0;
    else if (rx_par_bad) rx_parity_err_out <= 1'b1;
    else if (rx_rden_in) rx_parity_err_out <= 1'b0;
  end
`endif

endmodule
